// File: rtl/lock_entry_ctrl_pkg.sv
// lock_pkg: shared definitions for the code-lock entry sequencer.
//   KEY_STAR / KEY_HASH : keypad codes for '*' and '#'
//   state_t             : sequencer state encoding
//   is_digit()          : true for key codes 0-9
//   max3()              : largest of three ints, used to size the shared timer
package lock_pkg;

  localparam logic [3:0] KEY_STAR = 4'b1010;
  localparam logic [3:0] KEY_HASH = 4'b1011;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_OPEN    = 3'd2,
    S_NEW1    = 3'd3,
    S_NEW2    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_entry_ctrl_if.sv
// lock_entry_ctrl_if: keypad strobe in, indicator outputs back.
//   master : keypad side (drives key_valid/key_code, observes indicators)
//   slave  : sequencer side (consumes keys, drives indicators)
//   key_valid, key_code[3:0] : one-cycle key strobe and its code
//   open, lock, save_light, alarm : level indicators
//   err, saved               : one-cycle pulses
//   digit_cnt[3:0]           : digits currently buffered
interface lock_entry_ctrl_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       open;
  logic       lock;
  logic       save_light;
  logic       alarm;
  logic       err;
  logic       saved;
  logic [3:0] digit_cnt;

  modport master (
    output key_valid, key_code,
    input  open, lock, save_light, alarm, err, saved, digit_cnt
  );

  modport slave (
    input  key_valid, key_code,
    output open, lock, save_light, alarm, err, saved, digit_cnt
  );
endinterface

// File: rtl/lock_entry_ctrl_timer.sv
// lock_timer: loadable down-counter that stops at zero.
//   clk, reset_1   : clock, asynchronous active-high reset
//   load, load_val : load (or reload) the count
//   done           : count is zero
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_1,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset_1) begin
    if (reset_1) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lock_entry_ctrl.sv
// lock_entry_ctrl: keypad entry sequencer for the code lock.
// Buffers digits, checks them against the stored password, runs the
// password-change sequence and locks the keypad out after MAX_FAIL
// consecutive failed checks.
//   clk, reset_1 : clock, asynchronous active-high reset
//   bus (slave)  : key strobe in; open/lock/save_light/alarm levels,
//                  err/saved pulses and digit_cnt out
import lock_pkg::*;

module lock_entry_ctrl #(
  parameter int                    CODE_LEN       = 4,
  parameter int                    MAX_FAIL       = 3,
  parameter int                    OPEN_CYCLES    = 50_000_000,
  parameter int                    LOCKOUT_CYCLES = 500_000_000,
  parameter int                    ENTRY_TIMEOUT  = 250_000_000,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_PW     = 16'h1234
) (
  input  logic             clk,
  input  logic             reset_1,
  lock_entry_ctrl_if.slave bus
);

  localparam int BW = 4 * CODE_LEN;
  localparam int TW = $clog2(max3(OPEN_CYCLES, LOCKOUT_CYCLES, ENTRY_TIMEOUT)) + 1;
  localparam int FW = $clog2(MAX_FAIL) + 1;

  // The timer stops at zero and "done" is zero, so a period of P cycles
  // is loaded as P-1.
  localparam logic [TW-1:0] T_OPEN  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK  = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ENTRY = TW'(ENTRY_TIMEOUT - 1);
  localparam logic [3:0]    CL      = 4'(CODE_LEN);

  function automatic logic [BW-1:0] shift_in(input logic [BW-1:0] cur,
                                             input logic [3:0]    code);
    logic [BW-1:0] t;
    t      = cur << 4;
    t[3:0] = code;
    return t;
  endfunction

  state_t        state;
  logic          mode_change;
  logic [BW-1:0] entry, pw, new_buf;
  logic [3:0]    cnt;
  logic [FW-1:0] fail_cnt;
  logic          open_r, lock_r, save_r, alarm_r, err_r, saved_r;

  logic          key_dig, key_hash, key_star, key_any;
  logic          match, fail_hit, tmr_done, tmr_load;
  logic [TW-1:0] tmr_val;

  assign key_dig  = bus.key_valid && is_digit(bus.key_code);
  assign key_hash = bus.key_valid && (bus.key_code == KEY_HASH);
  assign key_star = bus.key_valid && (bus.key_code == KEY_STAR);
  assign key_any  = key_dig || key_hash || key_star;
  assign match    = (cnt == CL) && (entry == pw);
  assign fail_hit = (int'(fail_cnt) + 1) >= MAX_FAIL;

  // One timer serves open hold, lockout and entry timeout; the state
  // decides which period is loaded.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = T_ENTRY;
    case (state)
      S_IDLE:         tmr_load = key_any;
      S_NEW1, S_NEW2: tmr_load = key_any || tmr_done;
      S_CHECK: begin
        tmr_load = 1'b1;
        if (match && !mode_change)  tmr_val = T_OPEN;
        else if (!match && fail_hit) tmr_val = T_LOCK;
      end
      S_OPEN: begin
        tmr_load = key_hash || tmr_done;
        if (key_hash) tmr_val = T_OPEN;
      end
      S_LOCKOUT:      tmr_load = tmr_done;
      default:        tmr_load = 1'b0;
    endcase
  end

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset_1  (reset_1),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or posedge reset_1) begin
    if (reset_1) begin
      state       <= S_IDLE;
      mode_change <= 1'b0;
      entry       <= '0;
      new_buf     <= '0;
      pw          <= DEFAULT_PW;
      cnt         <= '0;
      fail_cnt    <= '0;
      open_r      <= 1'b0;
      lock_r      <= 1'b1;
      save_r      <= 1'b0;
      alarm_r     <= 1'b0;
      err_r       <= 1'b0;
      saved_r     <= 1'b0;
    end else begin
      err_r   <= 1'b0;
      saved_r <= 1'b0;
      // Indicators are a registered decode of the state, one cycle behind it.
      open_r  <= (state == S_OPEN);
      lock_r  <= (state != S_OPEN);
      save_r  <= (state == S_NEW1) || (state == S_NEW2);
      alarm_r <= (state == S_LOCKOUT);

      case (state)
        S_IDLE: begin
          if (key_dig) begin
            entry <= shift_in(entry, bus.key_code);
            if (cnt <= CL) cnt <= cnt + 4'd1;
          end else if (key_hash) begin
            mode_change <= 1'b0;
            state       <= S_CHECK;
          end else if (key_star) begin
            mode_change <= 1'b1;
            state       <= S_CHECK;
          end else if (tmr_done) begin
            entry <= '0;
            cnt   <= '0;
          end
        end

        S_CHECK: begin
          entry <= '0;
          cnt   <= '0;
          if (match) begin
            fail_cnt <= '0;
            state    <= mode_change ? S_NEW1 : S_OPEN;
          end else begin
            err_r <= 1'b1;
            if (fail_hit) begin
              fail_cnt <= FW'(MAX_FAIL);
              state    <= S_LOCKOUT;
            end else begin
              fail_cnt <= fail_cnt + FW'(1);
              state    <= S_IDLE;
            end
          end
        end

        S_OPEN: begin
          if (!key_hash && tmr_done) state <= S_IDLE;
        end

        S_NEW1, S_NEW2: begin
          if (key_dig) begin
            entry <= shift_in(entry, bus.key_code);
            if (cnt <= CL) cnt <= cnt + 4'd1;
          end else if (key_hash) begin
            entry <= '0;
            cnt   <= '0;
            if (state == S_NEW1) begin
              if (cnt == CL) begin
                new_buf <= entry;
                state   <= S_NEW2;
              end else begin
                err_r <= 1'b1;
                state <= S_IDLE;
              end
            end else begin
              if ((cnt == CL) && (entry == new_buf)) begin
                pw      <= new_buf;
                saved_r <= 1'b1;
              end else begin
                err_r <= 1'b1;
              end
              state <= S_IDLE;
            end
          end else if (key_star || tmr_done) begin
            entry <= '0;
            cnt   <= '0;
            state <= S_IDLE;
          end
        end

        S_LOCKOUT: begin
          if (tmr_done) begin
            fail_cnt <= '0;
            state    <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.open       = open_r;
  assign bus.lock       = lock_r;
  assign bus.save_light = save_r;
  assign bus.alarm      = alarm_r;
  assign bus.err        = err_r;
  assign bus.saved      = saved_r;
  assign bus.digit_cnt  = cnt;

endmodule

// File: tb/tb_lock_entry_ctrl.sv
// tb_lock_entry_ctrl: directed stimulus with an event scoreboard.
// Stimulus pushes the expected output events (kind + clock edge number);
// a monitor detects pulses and indicator transitions and pops/compares.
module tb_lock_entry_ctrl;

  localparam int EV_ERR     = 0;
  localparam int EV_SAVED   = 1;
  localparam int EV_OPEN_R  = 2;
  localparam int EV_OPEN_F  = 3;
  localparam int EV_ALARM_R = 4;
  localparam int EV_ALARM_F = 5;
  localparam int EV_SAVE_R  = 6;
  localparam int EV_SAVE_F  = 7;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_1;
  int   cyc = 0;
  int   last_edge = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  logic p_open, p_alarm, p_save;

  lock_entry_ctrl_if bus ();

  lock_entry_ctrl #(
    .CODE_LEN       (4),
    .MAX_FAIL       (3),
    .OPEN_CYCLES    (8),
    .LOCKOUT_CYCLES (16),
    .ENTRY_TIMEOUT  (32),
    .DEFAULT_PW     (16'h1234)
  ) dut (
    .clk     (clk),
    .reset_1 (reset_1),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string ev_name(input int k);
    case (k)
      EV_ERR:     return "err";
      EV_SAVED:   return "saved";
      EV_OPEN_R:  return "open_rise";
      EV_OPEN_F:  return "open_fall";
      EV_ALARM_R: return "alarm_rise";
      EV_ALARM_F: return "alarm_fall";
      EV_SAVE_R:  return "save_rise";
      EV_SAVE_F:  return "save_fall";
      default:    return "unknown";
    endcase
  endfunction

  task automatic expect_ev(input int kind, input int c);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got %s at edge %0d, required no event",
               ev_name(kind), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        n_bad++;
        $display("FAIL event_%s: got %s at edge %0d, required %s at edge %0d",
                 ev_name(e.kind), ev_name(kind), cyc, ev_name(e.kind), e.cyc);
      end
    end
  endtask

  task automatic chk(input string nm, input int actual, input int required);
    n_cmp++;
    if (actual != required) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", nm, actual, required, cyc);
    end
  endtask

  // Monitor: samples just after the falling edge, ignores reset periods.
  initial begin
    p_open = 1'b0; p_alarm = 1'b0; p_save = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_1) begin
        if (bus.err)                   got(EV_ERR);
        if (bus.saved)                 got(EV_SAVED);
        if (bus.open && !p_open)       got(EV_OPEN_R);
        if (!bus.open && p_open)       got(EV_OPEN_F);
        if (bus.alarm && !p_alarm)     got(EV_ALARM_R);
        if (!bus.alarm && p_alarm)     got(EV_ALARM_F);
        if (bus.save_light && !p_save) got(EV_SAVE_R);
        if (!bus.save_light && p_save) got(EV_SAVE_F);
      end
      p_open  = bus.open;
      p_alarm = bus.alarm;
      p_save  = bus.save_light;
    end
  end

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    last_edge     = cyc + 1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic keys(input logic [31:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) press(seq[4*i +: 4]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic open_and_close();
    keys(32'h1234B, 5);
    expect_ev(EV_OPEN_R, last_edge + 2);
    expect_ev(EV_OPEN_F, last_edge + 10);
    idle(12);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, m;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    reset_1       = 1'b1;
    idle(3);
    reset_1 = 1'b0;

    chk("rst_lock",       32'(bus.lock), 1);
    chk("rst_open",       32'(bus.open), 0);
    chk("rst_save_light", 32'(bus.save_light), 0);
    chk("rst_alarm",      32'(bus.alarm), 0);
    chk("rst_pulses",     32'({bus.err, bus.saved}), 0);
    chk("rst_digit_cnt",  32'(bus.digit_cnt), 0);

    // Correct code opens two edges after '#', for eight cycles.
    keys(32'h1234B, 5);
    n = last_edge;
    expect_ev(EV_OPEN_R, n + 2);
    expect_ev(EV_OPEN_F, n + 10);
    idle(1);
    chk("open_not_early", 32'(bus.open), 0);
    idle(1);
    chk("lock_low_while_open", 32'(bus.lock), 0);
    idle(10);
    chk("lock_after_open", 32'(bus.lock), 1);

    // Ignored code in the entry, then '#' in cycle 5 of OPEN extends it.
    keys(32'h12C34B, 6);
    n = last_edge;
    expect_ev(EV_OPEN_R, n + 2);
    idle(5);
    press(4'hB);
    m = last_edge;
    expect_ev(EV_OPEN_F, m + 9);
    idle(4);
    chk("open_extended", 32'(bus.open), 1);
    idle(8);
    chk("lock_after_extend", 32'(bus.lock), 1);

    // Three wrong codes lead to lockout; keys are ignored during it.
    for (int i = 0; i < 3; i++) begin
      keys(32'h1235B, 5);
      expect_ev(EV_ERR, last_edge + 1);
      if (i == 2) begin
        expect_ev(EV_ALARM_R, last_edge + 2);
        expect_ev(EV_ALARM_F, last_edge + 18);
      end
    end
    n = last_edge;
    keys(32'h1234B, 5);
    chk("alarm_during_lockout", 32'(bus.alarm), 1);
    chk("lock_during_lockout",  32'(bus.lock), 1);
    idle(n + 20 - cyc);
    chk("alarm_cleared", 32'(bus.alarm), 0);
    open_and_close();

    // Password change 1234 -> 9876.
    keys(32'h1234A, 5);
    expect_ev(EV_SAVE_R, last_edge + 2);
    keys(32'h9876B, 5);
    chk("save_light_new2", 32'(bus.save_light), 1);
    keys(32'h9876B, 5);
    expect_ev(EV_SAVED, last_edge);
    expect_ev(EV_SAVE_F, last_edge + 1);
    keys(32'h1234B, 5);
    expect_ev(EV_ERR, last_edge + 1);
    keys(32'h9876B, 5);
    expect_ev(EV_OPEN_R, last_edge + 2);
    expect_ev(EV_OPEN_F, last_edge + 10);
    idle(12);

    // Reset restores the default password.
    reset_1 = 1'b1;
    idle(1);
    reset_1 = 1'b0;
    chk("rst2_digit_cnt", 32'(bus.digit_cnt), 0);

    // Mismatched confirmation leaves 1234 in place.
    keys(32'h1234A, 5);
    expect_ev(EV_SAVE_R, last_edge + 2);
    keys(32'h9876B, 5);
    keys(32'h9870B, 5);
    expect_ev(EV_ERR, last_edge);
    expect_ev(EV_SAVE_F, last_edge + 1);
    idle(2);
    open_and_close();

    // Five digits overflow the entry.
    keys(32'h1234, 4);
    chk("digit_cnt_full", 32'(bus.digit_cnt), 4);
    press(4'h4);
    chk("digit_cnt_overflow", 32'(bus.digit_cnt), 5);
    press(4'hB);
    expect_ev(EV_ERR, last_edge + 1);

    // Idle timeout discards a partial entry.
    keys(32'h12, 2);
    chk("digit_cnt_partial", 32'(bus.digit_cnt), 2);
    idle(20);
    chk("digit_cnt_before_timeout", 32'(bus.digit_cnt), 2);
    idle(20);
    chk("digit_cnt_timeout", 32'(bus.digit_cnt), 0);
    keys(32'h34B, 3);
    expect_ev(EV_ERR, last_edge + 1);

    // Asynchronous reset while open.
    keys(32'h1234B, 5);
    expect_ev(EV_OPEN_R, last_edge + 2);
    idle(3);
    @(posedge clk);
    #2 reset_1 = 1'b1;
    #1;
    chk("async_rst_open", 32'(bus.open), 0);
    chk("async_rst_lock", 32'(bus.lock), 1);
    idle(2);
    reset_1 = 1'b0;
    idle(3);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events: got %0d unmatched, required 0 (next %s at edge %0d)",
               exp_q.size(), ev_name(exp_q[0].kind), exp_q[0].cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
